// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, RX FSM states and PID classification.
// The TX control FSM takes its PID constants from here too.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_HSEOP,
        S_TOKEN,
        S_DATA,
        S_STORE,
        S_DONE,
        S_ERRWAIT,
        S_ERROR
    } rx_state_t;

    typedef enum logic [1:0] {
        HANDSHAKE,
        TOKEN,
        DATA,
        INVALID
    } pid_class_t;

    // Upper nibble must be the one's complement of the code nibble.
    function automatic pid_class_t classify_pid(input logic [7:0] pid_byte);
        pid_class_t c;
        if (pid_byte[7:4] != ~pid_byte[3:0]) begin
            c = INVALID;
        end else begin
            case (pid_byte[3:0])
                PID_OUT, PID_IN:            c = TOKEN;
                PID_DATA0, PID_DATA1:       c = DATA;
                PID_ACK, PID_NAK, PID_STALL: c = HANDSHAKE;
                default:                    c = INVALID;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_rx_control_if.sv
// Byte stream from the RX datapath in, FIFO push and status to the AHB side out.
interface usb_rx_control_if;

    logic       d_edge;
    logic [7:0] rx_byte;
    logic       byte_received;
    logic       eop;
    logic [6:0] buffer_occupancy;
    logic [3:0] rx_packet;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data;
    logic       rx_data_ready;
    logic       rx_error;
    logic       rx_transfer_active;

    modport master (
        input  d_edge, rx_byte, byte_received, eop, buffer_occupancy,
        output rx_packet, rx_packet_data, store_rx_packet_data,
               rx_data_ready, rx_error, rx_transfer_active
    );

    modport slave (
        output d_edge, rx_byte, byte_received, eop, buffer_occupancy,
        input  rx_packet, rx_packet_data, store_rx_packet_data,
               rx_data_ready, rx_error, rx_transfer_active
    );

endinterface

// File: rtl/usb_rx_holdback.sv
// Two-byte delay line for data payloads: a byte only leaves once two newer
// bytes are behind it, so the trailing CRC16 never reaches the FIFO.
module usb_rx_holdback (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full
);

    logic [7:0] h0, h1;
    logic [1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h0  <= '0;
            h1  <= '0;
            cnt <= '0;
        end else if (clr) begin
            h0  <= '0;
            h1  <= '0;
            cnt <= '0;
        end else if (shift) begin
            h1 <= h0;
            h0 <= din;
            if (cnt != 2'd2) cnt <= cnt + 2'd1;
        end
    end

    assign dout = h1;
    assign full = (cnt == 2'd2);

endmodule

// File: rtl/usb_rx_control.sv
// USB full-speed receive control FSM: checks SYNC/PID, classifies the packet
// and forwards data payload bytes (minus CRC16) to the RX FIFO.
module usb_rx_control
    import usb_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = 8'b1000_0000,
    parameter int         FIFO_DEPTH = 64,
    parameter int         TIMEOUT    = 200
) (
    input logic              clk,
    input logic              rst,
    usb_rx_control_if.master bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    rx_state_t   state;
    logic [TW-1:0] timer;
    logic [1:0]  tok_cnt;
    logic        hb_full, hb_shift, hb_clr;
    logic [7:0]  hb_dout;
    logic        framing, occ_full, tmr_run, tmo;

    assign framing  = bus.byte_received && bus.eop;
    assign occ_full = (bus.buffer_occupancy == 7'(FIFO_DEPTH));
    assign tmr_run  = state inside {S_SYNC, S_PID, S_HSEOP, S_TOKEN, S_DATA, S_ERRWAIT};
    assign tmo      = tmr_run && !bus.byte_received && !bus.eop
                      && (timer == TW'(TIMEOUT - 1));

    // Every accepted data byte enters the delay line, except one refused on overflow.
    assign hb_shift = (state == S_DATA) && bus.byte_received && !bus.eop
                      && !(hb_full && occ_full);
    assign hb_clr   = (state == S_IDLE);

    usb_rx_holdback u_holdback (
        .clk   (clk),
        .rst   (rst),
        .clr   (hb_clr),
        .shift (hb_shift),
        .din   (bus.rx_byte),
        .dout  (hb_dout),
        .full  (hb_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= S_IDLE;
            timer                    <= '0;
            tok_cnt                  <= '0;
            bus.rx_packet            <= '0;
            bus.rx_packet_data       <= '0;
            bus.store_rx_packet_data <= 1'b0;
            bus.rx_data_ready        <= 1'b0;
            bus.rx_error             <= 1'b0;
            bus.rx_transfer_active   <= 1'b0;
        end else begin
            bus.store_rx_packet_data <= 1'b0;
            bus.rx_data_ready        <= 1'b0;
            bus.rx_error             <= 1'b0;
            bus.rx_transfer_active   <= 1'b1;

            if (state == S_IDLE || bus.byte_received || bus.eop) timer <= '0;
            else if (tmr_run)                                   timer <= timer + 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.d_edge) state <= S_SYNC;
                    else            bus.rx_transfer_active <= 1'b0;
                end
                S_DONE, S_ERROR: begin
                    state                  <= S_IDLE;
                    bus.rx_transfer_active <= 1'b0;
                end
                S_STORE: begin
                    if (framing) begin
                        state        <= S_ERROR;
                        bus.rx_error <= 1'b1;
                    end else begin
                        state <= S_DATA;
                    end
                end
                default: begin
                    if (framing || tmo) begin
                        state        <= S_ERROR;
                        bus.rx_error <= 1'b1;
                    end else begin
                        case (state)
                            S_SYNC: begin
                                if (bus.byte_received)
                                    state <= (bus.rx_byte == SYNC_BYTE) ? S_PID : S_ERRWAIT;
                                else if (bus.eop) begin
                                    state        <= S_ERROR;
                                    bus.rx_error <= 1'b1;
                                end
                            end
                            S_PID: begin
                                if (bus.byte_received) begin
                                    if (classify_pid(bus.rx_byte) != INVALID)
                                        bus.rx_packet <= bus.rx_byte[3:0];
                                    case (classify_pid(bus.rx_byte))
                                        HANDSHAKE: state <= S_HSEOP;
                                        TOKEN: begin
                                            state   <= S_TOKEN;
                                            tok_cnt <= '0;
                                        end
                                        DATA:    state <= S_DATA;
                                        default: state <= S_ERRWAIT;
                                    endcase
                                end else if (bus.eop) begin
                                    state        <= S_ERROR;
                                    bus.rx_error <= 1'b1;
                                end
                            end
                            S_HSEOP: begin
                                if (bus.eop) begin
                                    state             <= S_DONE;
                                    bus.rx_data_ready <= 1'b1;
                                end else if (bus.byte_received) begin
                                    state <= S_ERRWAIT;
                                end
                            end
                            S_TOKEN: begin
                                if (bus.eop) begin
                                    if (tok_cnt == 2'd2) begin
                                        state             <= S_DONE;
                                        bus.rx_data_ready <= 1'b1;
                                    end else begin
                                        state        <= S_ERROR;
                                        bus.rx_error <= 1'b1;
                                    end
                                end else if (bus.byte_received) begin
                                    if (tok_cnt == 2'd2) state <= S_ERRWAIT;
                                    else                 tok_cnt <= tok_cnt + 2'd1;
                                end
                            end
                            S_DATA: begin
                                // The two bytes still held at EOP are the CRC16 and are dropped.
                                if (bus.eop) begin
                                    if (hb_full) begin
                                        state             <= S_DONE;
                                        bus.rx_data_ready <= 1'b1;
                                    end else begin
                                        state        <= S_ERROR;
                                        bus.rx_error <= 1'b1;
                                    end
                                end else if (bus.byte_received && hb_full) begin
                                    if (occ_full) begin
                                        state <= S_ERRWAIT;
                                    end else begin
                                        state                    <= S_STORE;
                                        bus.rx_packet_data       <= hb_dout;
                                        bus.store_rx_packet_data <= 1'b1;
                                    end
                                end
                            end
                            S_ERRWAIT: begin
                                if (bus.eop) begin
                                    state        <= S_ERROR;
                                    bus.rx_error <= 1'b1;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_control.sv
// Directed checks of the USB RX control FSM: handshake, data, token,
// error paths, overflow, timeout and asynchronous reset.
module tb_usb_rx_control;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_rx_control_if bus();

    usb_rx_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse/push monitor, sampled on the falling edge.
    int n_push = 0, n_rdy = 0, n_err = 0, lat_bad = 0;
    logic prev_byte = 1'b0;
    logic [7:0] push_log [64];

    always @(negedge clk) begin
        if (bus.store_rx_packet_data) begin
            if (n_push < 64) push_log[n_push] = bus.rx_packet_data;
            n_push++;
            if (!prev_byte) lat_bad++;
        end
        if (bus.rx_data_ready) n_rdy++;
        if (bus.rx_error)      n_err++;
        prev_byte = bus.byte_received;
    end

    int b_push, b_rdy, b_err;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_push = n_push;
        b_rdy  = n_rdy;
        b_err  = n_err;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte       = b;
        bus.byte_received = 1'b1;
        cyc();
        bus.byte_received = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic send_eop();
        bus.eop = 1'b1;
        cyc();
        bus.eop = 1'b0;
    endtask

    task automatic start_pkt(input logic [7:0] pid);
        bus.d_edge = 1'b1;
        cyc();
        bus.d_edge = 1'b0;
        send_byte(8'h80);
        send_byte(pid);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pkt"},    32'(bus.rx_packet), 0);
        chk({tag, "_data"},   32'(bus.rx_packet_data), 0);
        chk({tag, "_store"},  32'(bus.store_rx_packet_data), 0);
        chk({tag, "_rdy"},    32'(bus.rx_data_ready), 0);
        chk({tag, "_err"},    32'(bus.rx_error), 0);
        chk({tag, "_active"}, 32'(bus.rx_transfer_active), 0);
    endtask

    initial begin
        rst                  = 1'b1;
        bus.d_edge           = 1'b0;
        bus.rx_byte          = 8'h00;
        bus.byte_received    = 1'b0;
        bus.eop              = 1'b0;
        bus.buffer_occupancy = 7'd0;
        cyc();
        cyc();
        chk_all_zero("reset");
        rst = 1'b0;
        cyc();

        // ACK handshake
        snap();
        start_pkt(8'hD2);
        send_eop();
        chk("ack_rdy_pulse", 32'(bus.rx_data_ready), 1);
        chk("ack_active", 32'(bus.rx_transfer_active), 1);
        cyc();
        chk("ack_idle", 32'(bus.rx_transfer_active), 0);
        chk("ack_pid", 32'(bus.rx_packet), 32'h2);
        chk("ack_rdy_cnt", 32'(n_rdy - b_rdy), 1);
        chk("ack_push_cnt", 32'(n_push - b_push), 0);
        chk("ack_err_cnt", 32'(n_err - b_err), 0);

        // DATA0 AA BB CC + CRC 12 34, FIFO one short of full
        bus.buffer_occupancy = 7'd63;
        snap();
        start_pkt(8'hC3);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'h12);
        send_byte(8'h34);
        send_eop();
        chk("d0_rdy_pulse", 32'(bus.rx_data_ready), 1);
        cyc();
        bus.buffer_occupancy = 7'd0;
        chk("d0_push_cnt", 32'(n_push - b_push), 3);
        chk("d0_push0", 32'(push_log[b_push]), 32'hAA);
        chk("d0_push1", 32'(push_log[b_push + 1]), 32'hBB);
        chk("d0_push2", 32'(push_log[b_push + 2]), 32'hCC);
        chk("d0_pid", 32'(bus.rx_packet), 32'h3);
        chk("d0_rdy_cnt", 32'(n_rdy - b_rdy), 1);
        chk("d0_err_cnt", 32'(n_err - b_err), 0);

        // Bad PID (nibbles not complementary)
        snap();
        start_pkt(8'h11);
        send_byte(8'h01);
        send_byte(8'h02);
        chk("bad_no_err_early", 32'(n_err - b_err), 0);
        send_eop();
        chk("bad_err_pulse", 32'(bus.rx_error), 1);
        cyc();
        chk("bad_idle", 32'(bus.rx_transfer_active), 0);
        chk("bad_push_cnt", 32'(n_push - b_push), 0);
        chk("bad_err_cnt", 32'(n_err - b_err), 1);
        chk("bad_pid_held", 32'(bus.rx_packet), 32'h3);

        // Overflow on the first byte that would be pushed
        bus.buffer_occupancy = 7'd64;
        snap();
        start_pkt(8'hC3);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_eop();
        chk("ovf_err_pulse", 32'(bus.rx_error), 1);
        cyc();
        bus.buffer_occupancy = 7'd0;
        chk("ovf_push_cnt", 32'(n_push - b_push), 0);
        chk("ovf_err_cnt", 32'(n_err - b_err), 1);
        chk("ovf_rdy_cnt", 32'(n_rdy - b_rdy), 0);

        // DATA1 with a single byte
        snap();
        start_pkt(8'h4B);
        send_byte(8'h5A);
        send_eop();
        chk("short_err_pulse", 32'(bus.rx_error), 1);
        cyc();
        chk("short_push_cnt", 32'(n_push - b_push), 0);
        chk("short_pid", 32'(bus.rx_packet), 32'hB);

        // OUT token with three bytes
        snap();
        start_pkt(8'hE1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_eop();
        chk("tok3_err_pulse", 32'(bus.rx_error), 1);
        cyc();
        chk("tok3_pid", 32'(bus.rx_packet), 32'h1);
        chk("tok3_rdy_cnt", 32'(n_rdy - b_rdy), 0);

        // OUT token with the correct two bytes
        snap();
        start_pkt(8'hE1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_eop();
        chk("tok2_rdy_pulse", 32'(bus.rx_data_ready), 1);
        cyc();
        chk("tok2_err_cnt", 32'(n_err - b_err), 0);

        // byte_received and eop together
        snap();
        start_pkt(8'hC3);
        send_byte(8'hAA);
        bus.rx_byte       = 8'hBB;
        bus.byte_received = 1'b1;
        bus.eop           = 1'b1;
        cyc();
        bus.byte_received = 1'b0;
        bus.eop           = 1'b0;
        chk("frame_err_pulse", 32'(bus.rx_error), 1);
        cyc();
        chk("frame_idle", 32'(bus.rx_transfer_active), 0);

        // Timeout: SYNC then silence
        snap();
        bus.d_edge = 1'b1;
        cyc();
        bus.d_edge        = 1'b0;
        bus.rx_byte       = 8'h80;
        bus.byte_received = 1'b1;
        cyc();
        bus.byte_received = 1'b0;
        repeat (199) cyc();
        chk("tmo_not_yet", 32'(bus.rx_error), 0);
        chk("tmo_active", 32'(bus.rx_transfer_active), 1);
        cyc();
        chk("tmo_err_pulse", 32'(bus.rx_error), 1);
        cyc();
        chk("tmo_idle", 32'(bus.rx_transfer_active), 0);
        chk("tmo_err_cnt", 32'(n_err - b_err), 1);

        // Asynchronous reset mid-DATA while a push is active
        start_pkt(8'hC3);
        send_byte(8'hAA);
        send_byte(8'hBB);
        bus.rx_byte       = 8'hCC;
        bus.byte_received = 1'b1;
        cyc();
        bus.byte_received = 1'b0;
        chk("pre_rst_store", 32'(bus.store_rx_packet_data), 1);
        chk("pre_rst_data", 32'(bus.rx_packet_data), 32'hAA);
        #1 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        // Recovery after reset
        snap();
        start_pkt(8'hD2);
        send_eop();
        chk("post_rst_rdy", 32'(bus.rx_data_ready), 1);
        cyc();

        chk("push_latency", 32'(lat_bad), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
